// File: rtl/result_writeback_pkg.sv
// result_writeback_pkg
//   Shared build configuration and helpers for the result write-back stage.
//   The `ifndef guards give the shared config header's values. A project
//   config header compiled ahead of this file overrides them.
`ifndef S2P_SIZE
`define S2P_SIZE 4
`endif
`ifndef RESULT_SIZE
`define RESULT_SIZE 16
`endif
`ifndef KERNEL_NUMS_SIZE
`define KERNEL_NUMS_SIZE 8
`endif
`ifndef WB_FIFO_DEPTH
`define WB_FIFO_DEPTH 16
`endif

package result_writeback_pkg;

  localparam int WB_S_DEF     = `S2P_SIZE;
  localparam int WB_RW_DEF    = `RESULT_SIZE;
  localparam int WB_KW_DEF    = `KERNEL_NUMS_SIZE;
  localparam int WB_DEPTH_DEF = `WB_FIFO_DEPTH;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock show-ahead FIFO. The head entry is visible on o_data
//   whenever o_empty is low. A push into a full FIFO is accepted only if a
//   pop happens in the same cycle. Otherwise the push is ignored, and the
//   caller decides what that means.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   i_clear        synchronous flush, wins over push/pop
//   i_push, i_data write request and data
//   i_pop          read request (ignored when empty)
//   o_data         head entry
//   o_full,o_empty occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr, rd_ptr;
  logic [PTRW:0]    count;
  logic             do_push, do_pop;

  assign o_full  = (count == (PTRW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign do_push = i_push && (!o_full || i_pop);
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !i_clear) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_writeback.sv
// result_writeback
//   Takes the serial tile stream from matrix_add and drops tensor-padded and
//   kernel-padded elements. Applies optional ReLU and computes the kernel-major
//   feature-map address (kern*out_pixels + pix). The result goes through a
//   capture register into a FIFO that drains over a valid/ready write port.
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   i_start                       layer start pulse, clears everything
//   i_relu_en                     clamp negative data to zero
//   i_out_pixels, i_t_tiles,
//   i_kernel_nums                 layer geometry
//   i_result, i_result_valid      element stream ([1] active, [0] not padded)
//   i_conv_done                   level, rises after the last element
//   o_wr_valid, i_wr_ready,
//   o_wr_addr, o_wr_data          write port to feature-map memory
//   o_overflow                    sticky: an element was lost
//   o_wb_done                     layer fully drained (level)
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int S     = WB_S_DEF,
  parameter int RW    = WB_RW_DEF,
  parameter int PW    = 16,
  parameter int KW    = WB_KW_DEF,
  parameter int AW    = 24,
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_start,
  input  logic          i_relu_en,
  input  logic [PW-1:0] i_out_pixels,
  input  logic [PW-1:0] i_t_tiles,
  input  logic [KW-1:0] i_kernel_nums,
  input  logic [RW-1:0] i_result,
  input  logic [3:0]    i_result_valid,
  input  logic          i_conv_done,
  output logic          o_wr_valid,
  input  logic          i_wr_ready,
  output logic [AW-1:0] o_wr_addr,
  output logic [RW-1:0] o_wr_data,
  output logic          o_overflow,
  output logic          o_wb_done
);

  localparam int SW = clog2_min1(S);
  localparam int FW = PW + KW + SW;

  logic [SW-1:0] row, col;
  logic [PW-1:0] t;
  logic [KW-1:0] w;
  logic          stream, row_last, col_last, t_last;
  logic [FW-1:0] pix, kern, addr_full;
  logic          elem_ok;
  logic [RW-1:0] elem_data;

  logic          cap_vld, cap_blocked, fifo_push, fifo_pop;
  logic [AW-1:0] cap_addr;
  logic [RW-1:0] cap_data;
  logic [AW+RW-1:0] fifo_dout;
  logic          fifo_full, fifo_empty;

  logic          conv_q, conv_seen, done_r, done_now;
  logic          unused_valid_bits;

  assign unused_valid_bits = ^i_result_valid[3:2];

  assign stream   = i_result_valid[1];
  assign row_last = (row == SW'(S-1));
  assign col_last = (col == SW'(S-1));
  assign t_last   = (t == PW'(i_t_tiles - PW'(1)));

  // Indices at full width; truncation to AW happens only on the address.
  assign pix       = FW'(t) * FW'(S) + FW'(row);
  assign kern      = FW'(w) * FW'(S) + FW'(col);
  assign addr_full = kern * FW'(i_out_pixels) + pix;

  assign elem_ok   = stream && i_result_valid[0] &&
                     (pix < FW'(i_out_pixels)) && (kern < FW'(i_kernel_nums));
  assign elem_data = (i_relu_en && i_result[RW-1]) ? '0 : i_result;

  // Position counters advance on every active stream cycle, written or not.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row <= '0;
      col <= '0;
      t   <= '0;
      w   <= '0;
    end else if (i_start) begin
      row <= '0;
      col <= '0;
      t   <= '0;
      w   <= '0;
    end else if (stream) begin
      if (row_last) begin
        row <= '0;
        if (col_last) begin
          col <= '0;
          if (t_last) begin
            t <= '0;
            w <= w + KW'(1);
          end else begin
            t <= t + PW'(1);
          end
        end else begin
          col <= col + SW'(1);
        end
      end else begin
        row <= row + SW'(1);
      end
    end
  end

  // A capture entry facing a full FIFO with no pop waits in place. Any new
  // writable element that arrives meanwhile is the one that is lost, so the
  // retained data stays in stream order.
  assign fifo_pop    = o_wr_valid && i_wr_ready;
  assign cap_blocked = cap_vld && fifo_full && !fifo_pop;
  assign fifo_push   = cap_vld && !cap_blocked;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_vld    <= 1'b0;
      cap_addr   <= '0;
      cap_data   <= '0;
      o_overflow <= 1'b0;
    end else if (i_start) begin
      cap_vld    <= 1'b0;
      cap_addr   <= '0;
      cap_data   <= '0;
      o_overflow <= 1'b0;
    end else if (!cap_blocked) begin
      cap_vld <= elem_ok;
      if (elem_ok) begin
        cap_addr <= AW'(addr_full);
        cap_data <= elem_data;
      end
    end else if (elem_ok) begin
      o_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (AW + RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_clear (i_start),
    .i_push  (fifo_push),
    .i_data  ({cap_addr, cap_data}),
    .i_pop   (fifo_pop),
    .o_data  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // FIFO memory is not reset; gate the head so the port reads zero when idle.
  assign o_wr_valid = !fifo_empty;
  assign o_wr_addr  = fifo_empty ? '0 : fifo_dout[AW+RW-1:RW];
  assign o_wr_data  = fifo_empty ? '0 : fifo_dout[RW-1:0];

  // conv_q follows i_conv_done even across i_start. A level that is still
  // high from the previous layer is then not taken as a fresh edge.
  assign done_now  = conv_seen && !cap_vld && fifo_empty;
  assign o_wb_done = done_r || done_now;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conv_q    <= 1'b0;
      conv_seen <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      conv_q <= i_conv_done;
      if (i_start) begin
        conv_seen <= 1'b0;
        done_r    <= 1'b0;
      end else begin
        if (i_conv_done && !conv_q) conv_seen <= 1'b1;
        if (done_now)               done_r    <= 1'b1;
      end
    end
  end

endmodule
